conv_kxk_mac: RTL and testbench
===============================

CONV_KXK_MAC -- requirements
Module: conv_kxk_mac

Interface
REQ-001 SHALL have parameter K, default 3, window edge length; legal values 3, 5, 7.
REQ-002 SHALL have parameter PW, default 8, unsigned pixel width.
REQ-003 SHALL have parameter KW, default 9, signed two's-complement kernel coefficient width.
REQ-004 SHALL derive localparam AW = PW+KW+clog2(K*K) as the signed accumulator width.
REQ-005 clk  input  1  clock, rising-edge active.
REQ-006 reset  input  1  asynchronous, active-low reset.
REQ-007 start  input  1  request to start one convolution; sampled only in IDLE.
REQ-008 win_pix  input  K*K*PW  pixel window; tap i occupies bits [i*PW +: PW]; tap 0 is top-left, row-major.
REQ-009 win_ker  input  K*K*KW  kernel coefficients; tap i occupies bits [i*KW +: KW].
REQ-010 shift  input  5  arithmetic right-shift normalisation amount, sampled with start.
REQ-011 abs_mode  input  1  1 = output the magnitude of the normalised sum, sampled with start.
REQ-012 busy  output  1  high from the start-accept edge until the output handshake edge.
REQ-013 out_valid  output  1  data_out and sat are valid.
REQ-014 out_ready  input  1  downstream accepts the result.
REQ-015 data_out  output  PW  clamped result.
REQ-016 sat  output  1  result was clamped.

Function
REQ-017 SHALL implement FSM states IDLE, MAC, NORM, HOLD.
REQ-018 SHALL, in IDLE with start=1, register win_pix, win_ker, shift and abs_mode, clear the accumulator, set tap=0, and go to MAC.
REQ-019 SHALL ignore start in every state other than IDLE, with no effect on the current operation.
REQ-020 SHALL, in MAC, add zero-extended pixel[tap] times signed kernel[tap] to the AW-bit signed accumulator, one tap per cycle, for taps 0..K*K-1 in order.
REQ-021 SHALL leave MAC for NORM on the edge that accumulates tap K*K-1; the accumulator SHALL never overflow at AW bits.
REQ-022 SHALL, in NORM, compute r = acc >>> shift (sign-fill), with shift >= AW giving 0 or -1.
REQ-023 SHALL, in NORM with abs_mode=1, replace r by |r|.
REQ-024 SHALL clamp in NORM: r<0 gives 0; r>2^PW-1 gives 2^PW-1; otherwise r[PW-1:0].
REQ-025 SHALL set sat=1 exactly when REQ-024 clamped, and sat=0 otherwise.
REQ-026 SHALL register data_out and sat in NORM, then enter HOLD with out_valid=1.
REQ-027 SHALL assert out_valid K*K+1 cycles after the start-accept edge (10 cycles for K=3).
REQ-028 SHALL hold data_out, sat and out_valid stable in HOLD while out_ready=0.
REQ-029 SHALL, in HOLD with out_ready=1, complete the handshake on that edge: out_valid=0, busy=0, next state IDLE.
REQ-030 SHALL accept a start no earlier than the cycle after the handshake; data_out SHALL keep its last value in IDLE.
REQ-031 SHALL ignore out_ready outside HOLD.
REQ-032 SHALL not depend on win_pix, win_ker, shift or abs_mode after the start-accept edge.

Reset
REQ-033 SHALL, on reset=0 in any state including mid-MAC, immediately force state=IDLE, tap=0, acc=0, busy=0, out_valid=0, data_out=0 and sat=0.
REQ-034 SHALL accept start on the first rising edge after reset deasserts.

Verification
REQ-035 K=3, all pixels 90, all kernels 1, shift=3, abs_mode=0 -> acc 810, data_out=101, sat=0, out_valid 10 cycles after start.
REQ-036 All pixels 100, all kernels 1, shift=0 -> acc 900, data_out=255, sat=1.
REQ-037 Sobel kernel (-1,0,1,-2,0,2,-1,0,1), left column 200, centre column 0, right column 50 -> acc -600. With abs_mode=0, shift=0 -> data_out=0, sat=1. With abs_mode=1, shift=2 -> data_out=150, sat=0.
REQ-038 Tap 4: pixel 255, kernel -256, all other taps 0, abs_mode=1, shift=8 -> -65280>>>8=-255, data_out=255, sat=0.
REQ-039 Hold out_ready=0 for 5 cycles and pulse start during HOLD -> data_out, sat and out_valid stable, busy=1, start ignored. Raise out_ready -> IDLE on the next edge, busy=0.
REQ-040 Assert reset while tap=4, then deassert and issue the REQ-035 stimulus -> all outputs 0 during reset, then data_out=101 with correct latency.

Source files
------------

// File: rtl/conv_kxk_mac_if.sv
// Handshake bundle for conv_kxk_mac: start/window/kernel request in,
// clamped result out with valid/ready.
// Ports (master side drives): start, win_pix, win_ker, shift, abs_mode,
//   out_ready; (slave side drives): busy, out_valid, data_out, sat.
interface conv_kxk_mac_if #(
   parameter int K  = 3,
   parameter int PW = 8,
   parameter int KW = 9
);
   logic              start;
   logic [K*K*PW-1:0] win_pix;
   logic [K*K*KW-1:0] win_ker;
   logic [4:0]        shift;
   logic              abs_mode;
   logic              busy;
   logic              out_valid;
   logic              out_ready;
   logic [PW-1:0]     data_out;
   logic              sat;

   modport master (
      output start, win_pix, win_ker, shift, abs_mode, out_ready,
      input  busy, out_valid, data_out, sat
   );

   modport slave (
      input  start, win_pix, win_ker, shift, abs_mode, out_ready,
      output busy, out_valid, data_out, sat
   );
endinterface

// File: rtl/conv_kxk_mac.sv
// Sequential KxK convolution MAC: one tap per cycle, then shift, optional
// magnitude and clamp to PW bits.
// Ports: clk, reset (async, active-low), bus (conv_kxk_mac_if.slave).
module conv_kxk_mac #(
   parameter int K  = 3,
   parameter int PW = 8,
   parameter int KW = 9
) (
   input logic           clk,
   input logic           reset,
   conv_kxk_mac_if.slave bus
);
   localparam int N  = K * K;
   localparam int AW = PW + KW + $clog2(N);
   localparam int TW = $clog2(N);
   localparam int MW = PW + KW + 1;
   localparam logic signed [AW:0] MAXV = {{(AW + 1 - PW){1'b0}}, {PW{1'b1}}};

   typedef enum logic [1:0] {IDLE, MAC, NORM, HOLD} state_t;

   state_t               state;
   logic [TW-1:0]        tap;
   logic signed [AW-1:0] acc;
   logic [N*PW-1:0]      pix_q;
   logic [N*KW-1:0]      ker_q;
   logic [4:0]           shift_q;
   logic                 abs_q;
   logic                 busy_q;
   logic                 valid_q;
   logic [PW-1:0]        data_q;
   logic                 sat_q;

   logic [PW-1:0]        pix_cur;
   logic signed [KW-1:0] ker_cur;
   logic signed [MW-1:0] prod;
   logic signed [AW-1:0] r_sh;
   logic signed [AW:0]   r_ext;
   logic signed [AW:0]   r_mag;
   logic [PW-1:0]        clamp_d;
   logic                 clamp_s;

   always_comb begin
      pix_cur = pix_q[int'(tap) * PW +: PW];
      ker_cur = ker_q[int'(tap) * KW +: KW];
      // pixel is zero-extended so the product keeps the kernel's sign
      prod = MW'($signed({1'b0, pix_cur})) * MW'(ker_cur);
      r_sh = acc >>> shift_q;
      // one extra bit so negating the most negative value cannot wrap
      r_ext = {r_sh[AW-1], r_sh};
      r_mag = (abs_q && r_ext < 0) ? -r_ext : r_ext;
      clamp_d = r_mag[PW-1:0];
      clamp_s = 1'b0;
      if (r_mag < 0) begin
         clamp_d = '0;
         clamp_s = 1'b1;
      end else if (r_mag > MAXV) begin
         clamp_d = '1;
         clamp_s = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state   <= IDLE;
         tap     <= '0;
         acc     <= '0;
         pix_q   <= '0;
         ker_q   <= '0;
         shift_q <= '0;
         abs_q   <= 1'b0;
         busy_q  <= 1'b0;
         valid_q <= 1'b0;
         data_q  <= '0;
         sat_q   <= 1'b0;
      end else begin
         unique case (state)
            IDLE: begin
               if (bus.start) begin
                  pix_q   <= bus.win_pix;
                  ker_q   <= bus.win_ker;
                  shift_q <= bus.shift;
                  abs_q   <= bus.abs_mode;
                  acc     <= '0;
                  tap     <= '0;
                  busy_q  <= 1'b1;
                  state   <= MAC;
               end
            end
            MAC: begin
               acc <= acc + AW'(prod);
               tap <= tap + 1'b1;
               if (tap == TW'(N - 1)) begin
                  tap   <= '0;
                  state <= NORM;
               end
            end
            NORM: begin
               data_q  <= clamp_d;
               sat_q   <= clamp_s;
               valid_q <= 1'b1;
               state   <= HOLD;
            end
            HOLD: begin
               if (bus.out_ready) begin
                  valid_q <= 1'b0;
                  busy_q  <= 1'b0;
                  state   <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign bus.busy      = busy_q;
   assign bus.out_valid = valid_q;
   assign bus.data_out  = data_q;
   assign bus.sat       = sat_q;
endmodule

// File: tb/tb_conv_kxk_mac.sv
// Bench for conv_kxk_mac: transaction-level model checked every cycle,
// plus directed literal cases and random operations.
module tb_conv_kxk_mac;
   localparam int K  = 3;
   localparam int PW = 8;
   localparam int KW = 9;
   localparam int N  = K * K;

   logic clk = 1'b0;
   logic reset = 1'b0;
   int   n_chk = 0;
   int   n_fail = 0;
   bit   chk_en = 1'b0;

   conv_kxk_mac_if #(.K(K), .PW(PW), .KW(KW)) bus ();

   conv_kxk_mac #(.K(K), .PW(PW), .KW(KW)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   function automatic logic [PW:0] ref_calc(
      input logic [N*PW-1:0] p,
      input logic [N*KW-1:0] k,
      input int              sh,
      input bit              ab
   );
      longint s;
      longint r;
      logic [PW-1:0] pv;
      logic signed [KW-1:0] kv;
      s = 0;
      for (int i = 0; i < N; i++) begin
         pv = p[i*PW +: PW];
         kv = k[i*KW +: KW];
         s += longint'(pv) * longint'(kv);
      end
      r = s >>> sh;
      if (ab && r < 0) r = -r;
      if (r < 0) return {1'b1, {PW{1'b0}}};
      if (r > (1 << PW) - 1) return {1'b1, {PW{1'b1}}};
      return {1'b0, r[PW-1:0]};
   endfunction

   // transaction model: result appears N+1 edges after acceptance
   logic          m_busy = 1'b0;
   logic          m_valid = 1'b0;
   logic [PW-1:0] m_data = '0;
   logic          m_sat = 1'b0;
   logic [PW:0]   m_pend = '0;
   int            m_cnt = 0;

   always @(posedge clk or negedge reset) begin
      if (!reset) begin
         m_busy  <= 1'b0;
         m_valid <= 1'b0;
         m_data  <= '0;
         m_sat   <= 1'b0;
         m_cnt   <= 0;
      end else if (!m_busy) begin
         if (bus.start) begin
            m_pend <= ref_calc(bus.win_pix, bus.win_ker,
                               int'(bus.shift), bus.abs_mode);
            m_busy <= 1'b1;
            m_cnt  <= 0;
         end
      end else if (!m_valid) begin
         m_cnt <= m_cnt + 1;
         if (m_cnt + 1 == N + 1) begin
            m_valid <= 1'b1;
            m_data  <= m_pend[PW-1:0];
            m_sat   <= m_pend[PW];
         end
      end else if (bus.out_ready) begin
         m_valid <= 1'b0;
         m_busy  <= 1'b0;
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         n_chk++;
         if ({bus.busy, bus.out_valid, bus.sat, bus.data_out} !==
             {m_busy, m_valid, m_sat, m_data}) begin
            n_fail++;
            $display("FAIL cycle_check t=%0t got busy=%b valid=%b sat=%b data=%0d exp busy=%b valid=%b sat=%b data=%0d",
                     $time, bus.busy, bus.out_valid, bus.sat, bus.data_out,
                     m_busy, m_valid, m_sat, m_data);
         end
      end
   end

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0d exp=%0d", nm, act, exp);
      end
   endtask

   task automatic scramble();
      bus.win_pix  = {$urandom, $urandom, $urandom};
      bus.win_ker  = {$urandom, $urandom, $urandom};
      bus.shift    = 5'($urandom);
      bus.abs_mode = 1'($urandom);
   endtask

   // start while idle, wait for result, hold, handshake
   task automatic do_op(
      input  logic [N*PW-1:0] p,
      input  logic [N*KW-1:0] k,
      input  int              sh,
      input  bit              ab,
      input  int              hold,
      input  bit              rnd,
      output logic [PW-1:0]   d,
      output logic            s,
      output int              lat
   );
      bus.win_pix  = p;
      bus.win_ker  = k;
      bus.shift    = 5'(sh);
      bus.abs_mode = ab;
      bus.start    = 1'b1;
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      if (rnd) scramble();
      lat = 0;
      while (!bus.out_valid && lat < 40) begin
         if (rnd) bus.out_ready = 1'($urandom);
         @(posedge clk);
         #1;
         lat++;
      end
      bus.out_ready = 1'b0;
      if (!bus.out_valid) begin
         n_chk++;
         n_fail++;
         $display("FAIL timeout got=no_valid exp=valid");
      end
      d = bus.data_out;
      s = bus.sat;
      for (int i = 0; i < hold; i++) begin
         if (rnd) scramble();
         bus.start = 1'b1;
         @(posedge clk);
         #1;
         chk("hold_stable", {bus.busy, bus.out_valid, bus.sat, 23'd0, bus.data_out},
             {2'b11, s, 23'd0, d});
      end
      bus.start     = 1'b0;
      bus.out_ready = 1'b1;
      @(posedge clk);
      #1;
      bus.out_ready = 1'b0;
      chk("idle_busy", 32'(bus.busy), 32'd0);
   endtask

   function automatic logic [N*PW-1:0] fill_pix(input int v);
      logic [N*PW-1:0] r;
      for (int i = 0; i < N; i++) r[i*PW +: PW] = PW'(v);
      return r;
   endfunction

   function automatic logic [N*KW-1:0] fill_ker(input int v);
      logic [N*KW-1:0] r;
      for (int i = 0; i < N; i++) r[i*KW +: KW] = KW'(v);
      return r;
   endfunction

   initial begin
      logic [N*PW-1:0] p;
      logic [N*KW-1:0] k;
      logic [PW-1:0]   d;
      logic            s;
      int              lat;
      int              sob [N];
      int              col [3];
      int              sh;

      sob = '{-1, 0, 1, -2, 0, 2, -1, 0, 1};
      col = '{200, 0, 50};
      bus.start = 1'b0;
      bus.win_pix = '0;
      bus.win_ker = '0;
      bus.shift = '0;
      bus.abs_mode = 1'b0;
      bus.out_ready = 1'b0;
      @(posedge clk);
      #1;
      chk_en = 1'b1;
      chk("reset_outs", {bus.busy, bus.out_valid, bus.sat, 21'd0, bus.data_out}, 32'd0);
      @(posedge clk);
      #1;
      reset = 1'b1;

      do_op(fill_pix(90), fill_ker(1), 3, 0, 0, 0, d, s, lat);
      chk("r035_data", 32'(d), 32'd101);
      chk("r035_sat", 32'(s), 32'd0);
      chk("r035_latency", 32'(lat), 32'd10);

      do_op(fill_pix(100), fill_ker(1), 0, 0, 0, 0, d, s, lat);
      chk("r036_data", 32'(d), 32'd255);
      chk("r036_sat", 32'(s), 32'd1);

      for (int i = 0; i < N; i++) begin
         p[i*PW +: PW] = PW'(col[i % 3]);
         k[i*KW +: KW] = KW'(sob[i]);
      end
      do_op(p, k, 0, 0, 0, 0, d, s, lat);
      chk("r037a_data", 32'(d), 32'd0);
      chk("r037a_sat", 32'(s), 32'd1);
      do_op(p, k, 2, 1, 0, 0, d, s, lat);
      chk("r037b_data", 32'(d), 32'd150);
      chk("r037b_sat", 32'(s), 32'd0);

      p = '0;
      k = '0;
      p[4*PW +: PW] = 8'd255;
      k[4*KW +: KW] = 9'h100;
      do_op(p, k, 8, 1, 0, 0, d, s, lat);
      chk("r038_data", 32'(d), 32'd255);
      chk("r038_sat", 32'(s), 32'd0);

      do_op(fill_pix(90), fill_ker(1), 3, 0, 5, 1, d, s, lat);
      chk("r039_data", 32'(d), 32'd101);

      bus.win_pix = fill_pix(90);
      bus.win_ker = fill_ker(1);
      bus.shift = 5'd3;
      bus.abs_mode = 1'b0;
      bus.start = 1'b1;
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      reset = 1'b0;
      #1;
      chk("r040_reset_outs", {bus.busy, bus.out_valid, bus.sat, 21'd0, bus.data_out}, 32'd0);
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b1;
      do_op(fill_pix(90), fill_ker(1), 3, 0, 0, 0, d, s, lat);
      chk("r040_data", 32'(d), 32'd101);
      chk("r040_latency", 32'(lat), 32'd10);

      for (int t = 0; t < 40; t++) begin
         for (int i = 0; i < N; i++) begin
            p[i*PW +: PW] = PW'($urandom);
            if (t % 2 == 0) k[i*KW +: KW] = KW'($urandom);
            else k[i*KW +: KW] = KW'($urandom_range(0, 8) - 4);
         end
         sh = ($urandom_range(0, 7) == 0) ? $urandom_range(0, 31)
                                          : $urandom_range(0, 9);
         do_op(p, k, sh, 1'($urandom), $urandom_range(0, 3), 1,
               d, s, lat);
         chk("rnd_latency", 32'(lat), 32'd10);
      end

      repeat (2) @(posedge clk);
      #1;
      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end
endmodule
